// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, ALU function codes and FSM states for alu_seq_ctrl
package alu_seq_pkg;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_AND  = 6'h02;
    localparam logic [5:0] OP_OR   = 6'h03;
    localparam logic [5:0] OP_SLT  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LI   = 6'h09;
    localparam logic [5:0] OP_ANDI = 6'h0A;
    localparam logic [5:0] OP_NOP  = 6'h3F;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_e;

endpackage

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - combinational opcode decoder for alu_seq_ctrl
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [5:0] op_i,
    output logic       alu_src1_o,
    output logic       alu_src2_o,
    output logic [2:0] alu_op_o,
    output logic       imm_form_o,
    output logic       signed_op_o,
    output logic       legal_o
);

    always_comb begin
        alu_src1_o  = 1'b0;
        alu_src2_o  = 1'b0;
        alu_op_o    = ALU_AND;
        imm_form_o  = 1'b0;
        signed_op_o = 1'b0;
        legal_o     = 1'b1;
        case (op_i)
            OP_ADD:  begin alu_op_o = ALU_ADD; signed_op_o = 1'b1; end
            OP_SUB:  begin alu_op_o = ALU_SUB; signed_op_o = 1'b1; end
            OP_AND:  alu_op_o = ALU_AND;
            OP_OR:   alu_op_o = ALU_OR;
            OP_SLT:  alu_op_o = ALU_SLT;
            OP_ADDI: begin
                alu_src2_o  = 1'b1;
                alu_op_o    = ALU_ADD;
                imm_form_o  = 1'b1;
                signed_op_o = 1'b1;
            end
            // LI is 0 + imm: constant zero on A, immediate on B
            OP_LI: begin
                alu_src1_o = 1'b1;
                alu_src2_o = 1'b1;
                alu_op_o   = ALU_ADD;
                imm_form_o = 1'b1;
            end
            OP_ANDI: begin
                alu_src2_o = 1'b1;
                alu_op_o   = ALU_AND;
                imm_form_o = 1'b1;
            end
            OP_NOP:  legal_o = 1'b1;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - four-state issue/decode/execute/write-back sequencer for the ALU datapath
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit OVF_TRAP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr_in,
    output logic [ADDR_W-1:0] read_addr1,
    output logic [ADDR_W-1:0] read_addr2,
    output logic              reg_read,
    output logic              ALUSrc1,
    output logic              ALUSrc2,
    output logic [2:0]        ALUOp,
    output logic [15:0]       instr,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              ovf,
    input  logic              zero,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              reg_write,
    output logic              done,
    output logic              exc_ovf,
    output logic              exc_illegal,
    output logic              zero_flag
);

    state_e            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              zero_q, zero_d;
    logic              wen_q, wen_d;
    logic              exc_ovf_q, exc_ovf_d;
    logic              exc_ill_q, exc_ill_d;

    logic       dec_src1, dec_src2, dec_imm_form, dec_signed, dec_legal;
    logic [2:0] dec_alu_op;
    logic [4:0] dest;
    logic       is_nop, trap;

    alu_seq_decode u_decode (
        .op_i        (instr_q[31:26]),
        .alu_src1_o  (dec_src1),
        .alu_src2_o  (dec_src2),
        .alu_op_o    (dec_alu_op),
        .imm_form_o  (dec_imm_form),
        .signed_op_o (dec_signed),
        .legal_o     (dec_legal)
    );

    assign dest   = dec_imm_form ? instr_q[20:16] : instr_q[15:11];
    assign is_nop = (instr_q[31:26] == OP_NOP);
    assign trap   = OVF_TRAP && dec_signed && ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            data_q    <= '0;
            zero_q    <= 1'b0;
            wen_q     <= 1'b0;
            exc_ovf_q <= 1'b0;
            exc_ill_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            data_q    <= data_d;
            zero_q    <= zero_d;
            wen_q     <= wen_d;
            exc_ovf_q <= exc_ovf_d;
            exc_ill_q <= exc_ill_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        data_d      = data_q;
        zero_d      = zero_q;
        wen_d       = wen_q;
        exc_ovf_d   = exc_ovf_q;
        exc_ill_d   = exc_ill_q;
        instr_ready = 1'b0;
        read_addr1  = '0;
        read_addr2  = '0;
        reg_read    = 1'b0;
        ALUSrc1     = 1'b0;
        ALUSrc2     = 1'b0;
        ALUOp       = '0;
        instr       = '0;
        write_addr  = '0;
        reg_write   = 1'b0;
        done        = 1'b0;

        if (state_q == DECODE || state_q == EXEC) begin
            read_addr1 = ADDR_W'(instr_q[25:21]);
            read_addr2 = ADDR_W'(instr_q[20:16]);
            reg_read   = 1'b1;
            ALUSrc1    = dec_src1;
            ALUSrc2    = dec_src2;
            ALUOp      = dec_alu_op;
            instr      = instr_q[15:0];
        end

        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    instr_d   = instr_in;
                    exc_ovf_d = 1'b0;
                    exc_ill_d = 1'b0;
                    state_d   = DECODE;
                end
            end
            // Illegal ops still walk through EXEC so every instruction retires at a fixed latency
            DECODE: begin
                if (!dec_legal) exc_ill_d = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                wen_d = dec_legal && !is_nop && (dest != 5'd0) && !trap;
                if (dec_legal) begin
                    data_d = alu_result;
                    zero_d = zero;
                end
                if (trap) exc_ovf_d = 1'b1;
                state_d = WB;
            end
            WB: begin
                write_addr = ADDR_W'(dest);
                reg_write  = wen_q && !rst;
                done       = !rst;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign write_data  = data_q;
    assign exc_ovf     = exc_ovf_q;
    assign exc_illegal = exc_ill_q;
    assign zero_flag   = zero_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - scoreboard bench for alu_seq_ctrl with a behavioural datapath
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr_in;
    logic        instr_ready;
    logic [4:0]  read_addr1, read_addr2, write_addr;
    logic        reg_read, ALUSrc1, ALUSrc2, reg_write, done, exc_ovf, exc_illegal, zero_flag;
    logic [2:0]  ALUOp;
    logic [15:0] instr;
    logic [31:0] write_data;
    logic [31:0] alu_result;
    logic        ovf, zero;

    logic        d0_ready, d0_reg_read, d0_src1, d0_src2, d0_reg_write, d0_done;
    logic        d0_exc_ovf, d0_exc_ill, d0_zero_flag;
    logic [4:0]  d0_ra1, d0_ra2, d0_wa;
    logic [2:0]  d0_aluop;
    logic [15:0] d0_instr;
    logic [31:0] d0_wdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic rf_init;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq_ctrl #(.DATA_W(32), .ADDR_W(5), .OVF_TRAP(1'b1)) u_dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_in(instr_in), .read_addr1(read_addr1), .read_addr2(read_addr2),
        .reg_read(reg_read), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .ALUOp(ALUOp),
        .instr(instr), .alu_result(alu_result), .ovf(ovf), .zero(zero),
        .write_addr(write_addr), .write_data(write_data), .reg_write(reg_write),
        .done(done), .exc_ovf(exc_ovf), .exc_illegal(exc_illegal), .zero_flag(zero_flag)
    );

    alu_seq_ctrl #(.DATA_W(32), .ADDR_W(5), .OVF_TRAP(1'b0)) u_dut_notrap (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(d0_ready),
        .instr_in(instr_in), .read_addr1(d0_ra1), .read_addr2(d0_ra2),
        .reg_read(d0_reg_read), .ALUSrc1(d0_src1), .ALUSrc2(d0_src2), .ALUOp(d0_aluop),
        .instr(d0_instr), .alu_result(alu_result), .ovf(ovf), .zero(zero),
        .write_addr(d0_wa), .write_data(d0_wdata), .reg_write(d0_reg_write),
        .done(d0_done), .exc_ovf(d0_exc_ovf), .exc_illegal(d0_exc_ill), .zero_flag(d0_zero_flag)
    );

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // {ovf, result}
    function automatic logic [32:0] alu_f(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        o;
        r = 32'd0;
        o = 1'b0;
        case (code)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
            3'd6: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
            3'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return {o, r};
    endfunction

    // Behavioural datapath: register file, operand muxes and ALU
    logic [31:0] rf [32];
    logic [31:0] dp_a, dp_b;
    logic [32:0] dp_out;

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
            rf[5]  <= 32'h7FFF_FFFF;
            rf[6]  <= 32'd1;
            rf[14] <= 32'h8000_0000;
        end else if (reg_write) begin
            rf[write_addr] <= write_data;
        end
    end

    always_comb begin
        dp_a   = ALUSrc1 ? 32'd0 : rf[read_addr1];
        dp_b   = ALUSrc2 ? sext16(instr) : rf[read_addr2];
        dp_out = alu_f(ALUOp, dp_a, dp_b);
    end
    assign alu_result = dp_out[31:0];
    assign ovf        = dp_out[32];
    assign zero       = (dp_out[31:0] == 32'd0);

    typedef struct {
        logic        src1, src2, chk_ctl;
        logic [2:0]  code;
        logic [15:0] imm;
        logic        wen_t, wen_n, legal;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        eovf, eill, zero;
        int          done_cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [31:0] sh [32];
    logic        sh_zero;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [15:0] imm, input int dcyc);
        exp_t        x;
        logic        nop, sgn, immf;
        logic [31:0] a, b;
        logic [32:0] res;
        x.src1 = 1'b0; x.src2 = 1'b0; x.code = 3'd0; x.legal = 1'b1;
        nop = 1'b0; sgn = 1'b0; immf = 1'b0;
        case (op)
            6'h00: begin x.code = 3'd2; sgn = 1'b1; end
            6'h01: begin x.code = 3'd6; sgn = 1'b1; end
            6'h02: x.code = 3'd0;
            6'h03: x.code = 3'd1;
            6'h04: x.code = 3'd7;
            6'h08: begin x.src2 = 1'b1; x.code = 3'd2; immf = 1'b1; sgn = 1'b1; end
            6'h09: begin x.src1 = 1'b1; x.src2 = 1'b1; x.code = 3'd2; immf = 1'b1; end
            6'h0A: begin x.src2 = 1'b1; x.code = 3'd0; immf = 1'b1; end
            6'h3F: nop = 1'b1;
            default: x.legal = 1'b0;
        endcase
        a   = x.src1 ? 32'd0 : sh[rs];
        b   = x.src2 ? sext16(imm) : sh[rt];
        res = alu_f(x.code, a, b);
        x.imm      = imm;
        x.chk_ctl  = x.legal && !nop;
        x.addr     = immf ? rt : imm[15:11];
        x.data     = res[31:0];
        x.eovf     = sgn && res[32];
        x.eill     = !x.legal;
        x.wen_n    = x.legal && !nop && (x.addr != 5'd0);
        x.wen_t    = x.wen_n && !x.eovf;
        x.zero     = x.legal ? (res[31:0] == 32'd0) : sh_zero;
        x.done_cyc = dcyc;
        return x;
    endfunction

    always @(negedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) sh[i] = 32'd0;
            sh[5]   = 32'h7FFF_FFFF;
            sh[6]   = 32'd1;
            sh[14]  = 32'h8000_0000;
            sh_zero = 1'b0;
        end else if (!rst) begin
            chk("instr_ready", {31'd0, instr_ready}, {31'd0, q.size() == 0});
            if (q.size() == 0) begin
                chk("idle_done", {31'd0, done}, 32'd0);
                chk("idle_reg_write", {31'd0, reg_write}, 32'd0);
            end else begin
                e = q[0];
                if (reg_read && e.chk_ctl) begin
                    chk("ALUSrc1", {31'd0, ALUSrc1}, {31'd0, e.src1});
                    chk("ALUSrc2", {31'd0, ALUSrc2}, {31'd0, e.src2});
                    chk("ALUOp", {29'd0, ALUOp}, {29'd0, e.code});
                    chk("instr_imm", {16'd0, instr}, {16'd0, e.imm});
                end
                if (done || cyc >= e.done_cyc) begin
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("done", {31'd0, done}, 32'd1);
                    chk("reg_write", {31'd0, reg_write}, {31'd0, e.wen_t});
                    if (e.wen_t) begin
                        chk("write_addr", {27'd0, write_addr}, {27'd0, e.addr});
                        chk("write_data", write_data, e.data);
                    end
                    chk("exc_ovf", {31'd0, exc_ovf}, {31'd0, e.eovf});
                    chk("exc_illegal", {31'd0, exc_illegal}, {31'd0, e.eill});
                    if (e.chk_ctl || !e.legal) chk("zero_flag", {31'd0, zero_flag}, {31'd0, e.zero});
                    chk("notrap_done", {31'd0, d0_done}, 32'd1);
                    chk("notrap_reg_write", {31'd0, d0_reg_write}, {31'd0, e.wen_n});
                    if (e.wen_n) chk("notrap_write_data", d0_wdata, e.data);
                    chk("notrap_exc_ovf", {31'd0, d0_exc_ovf}, 32'd0);
                    chk("notrap_exc_illegal", {31'd0, d0_exc_ill}, {31'd0, e.eill});
                    if (e.wen_t) sh[e.addr] = e.data;
                    if (e.chk_ctl || !e.legal) sh_zero = e.zero;
                    void'(q.pop_front());
                end else begin
                    chk("early_reg_write", {31'd0, reg_write}, 32'd0);
                end
            end
        end
    end

    task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [15:0] imm, input bit hold, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        instr_in    = {op, rs, rt, imm};
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (!instr_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            instr_valid = 1'b0;
            acc = -1;
        end else begin
            @(posedge clk);
            #1;
            q.push_back(mk(op, rs, rt, imm, acc + 3));
            if (!hold) instr_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 32'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    function automatic logic [15:0] rimm(input logic [4:0] rd);
        return {rd, 11'd0};
    endfunction

    typedef struct { logic [5:0] op; logic [4:0] rs, rt; logic [15:0] imm; } stim_t;

    initial begin
        int    a0, a1, a2, ax;
        stim_t tbl[$];
        rst = 1'b1; rf_init = 1'b1; instr_valid = 1'b0; instr_in = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; rf_init = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_reg_read", {31'd0, reg_read}, 32'd0);
        chk("rst_ctl", {27'd0, ALUSrc1, ALUSrc2, ALUOp}, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_flags", {28'd0, exc_ovf, exc_illegal, zero_flag, done}, 32'd0);

        send(6'h09, 5'd0, 5'd1, 16'd5, 1'b0, ax);
        chk("li_accept_cycle", ax, cyc - 1);
        wait_idle();
        send(6'h09, 5'd0, 5'd2, 16'hFFFD, 1'b0, ax);
        wait_idle();
        send(6'h00, 5'd5, 5'd6, rimm(5'd3), 1'b0, ax);
        wait_idle();
        chk("exc_ovf_sticky", {31'd0, exc_ovf}, 32'd1);
        send(6'h15, 5'd1, 5'd2, rimm(5'd7), 1'b0, ax);
        wait_idle();
        chk("exc_illegal_sticky", {31'd0, exc_illegal}, 32'd1);

        tbl = '{
            '{6'h08, 5'd0, 5'd0, 16'd7},
            '{6'h01, 5'd1, 5'd1, rimm(5'd4)},
            '{6'h02, 5'd1, 5'd2, rimm(5'd7)},
            '{6'h03, 5'd1, 5'd2, rimm(5'd8)},
            '{6'h04, 5'd2, 5'd1, rimm(5'd9)},
            '{6'h0A, 5'd2, 5'd10, 16'h00F0},
            '{6'h08, 5'd1, 5'd11, 16'hFFFF},
            '{6'h01, 5'd6, 5'd5, rimm(5'd12)},
            '{6'h01, 5'd14, 5'd6, rimm(5'd15)},
            '{6'h3F, 5'd1, 5'd2, rimm(5'd13)},
            '{6'h00, 5'd1, 5'd1, rimm(5'd0)},
            '{6'h03, 5'd7, 5'd10, rimm(5'd13)}
        };
        foreach (tbl[i]) begin
            send(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].imm, 1'b0, ax);
            wait_idle();
        end

        send(6'h00, 5'd1, 5'd1, rimm(5'd16), 1'b1, a0);
        send(6'h08, 5'd1, 5'd17, 16'd100, 1'b1, a1);
        send(6'h03, 5'd1, 5'd6, rimm(5'd18), 1'b0, a2);
        chk("b2b_gap1", a1 - a0, 32'd4);
        chk("b2b_gap2", a2 - a1, 32'd4);
        wait_idle();

        send(6'h00, 5'd1, 5'd1, rimm(5'd19), 1'b0, ax);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("post_rst_reg_write", {31'd0, reg_write}, 32'd0);
        chk("post_rst_done", {31'd0, done}, 32'd0);
        send(6'h09, 5'd0, 5'd20, 16'd9, 1'b0, ax);
        wait_idle();
        repeat (4) @(negedge clk);
        chk("r19_not_written", rf[19], 32'd0);
        chk("r20_written", rf[20], 32'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
